// File: rtl/attn_row_sequencer.sv
// attn_row_sequencer
//   Single-FSM controller for the attention score datapath (MAC, e^x unit,
//   row-sum accumulator, normalize stage). It stages Q/K operand pairs from
//   a valid/ready byte stream and sequences the per-score MAC and e^x
//   capture. It then runs one row-sum sweep and issues normalized results
//   downstream under credit-based flow control.
//
//   Parameters: FEATURES (operand pairs per score), ROWLEN (scores per row),
//               CREDITS (downstream credit pool size).
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     s_data/s_vld/s_rdy  operand byte stream (signed Q0.7)
//     mac_a, mac_b        registered operand pair
//     mac_en, mac_clr     MAC accumulate / clear strokes
//     ex_cap, ex_idx      capture e^x of accumulator into slot ex_idx
//     sum_en, sum_clr     row-sum accumulate / clear
//     idx                 slot index during SUM and NORM
//     m_vld               normalized result for slot idx issued
//     crd_ret             downstream credit return
//     row_done            pulse on the final NORM issue of a row
//     crd_err             sticky credit-overflow flag
//     stall_cnt           NORM stall cycles with no credit
//   Build option: define ATTN_SEQ_STALL_CNT_EN to implement stall_cnt.
//   Without it, stall_cnt reads as zero.
module attn_row_sequencer #(
  parameter int unsigned FEATURES = 4,
  parameter int unsigned ROWLEN   = 4,
  parameter int unsigned CREDITS  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                s_data,
  input  logic                      s_vld,
  output logic                      s_rdy,
  output logic [7:0]                mac_a,
  output logic [7:0]                mac_b,
  output logic                      mac_en,
  output logic                      mac_clr,
  output logic                      ex_cap,
  output logic [$clog2(ROWLEN)-1:0] ex_idx,
  output logic                      sum_en,
  output logic                      sum_clr,
  output logic [$clog2(ROWLEN)-1:0] idx,
  output logic                      m_vld,
  input  logic                      crd_ret,
  output logic                      row_done,
  output logic                      crd_err,
  output logic [15:0]               stall_cnt
);

  localparam int unsigned IDX_W  = $clog2(ROWLEN);
  localparam int unsigned FEAT_W = $clog2(FEATURES);
  localparam int unsigned CRD_W  = $clog2(CREDITS + 1);

  localparam logic [FEAT_W-1:0] FEAT_LAST = FEAT_W'(FEATURES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(ROWLEN - 1);
  localparam logic [CRD_W-1:0]  CRD_FULL  = CRD_W'(CREDITS);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    MAC    = 3'd2,
    EXP    = 3'd3,
    SUM    = 3'd4,
    NORM   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [FEAT_W-1:0]   feat_q, feat_d;
  logic [IDX_W-1:0]    score_q, score_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CRD_W-1:0]    credit_q;
  logic                issue;

  // A result goes out in any NORM cycle that has at least one credit.
  assign issue = (state_q == NORM) && (credit_q != '0);

  assign ex_idx = score_q;
  assign idx    = idx_q;

  // State and sequencing counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      feat_q  <= '0;
      score_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      score_q <= score_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    score_d = score_q;
    idx_d   = idx_q;
    case (state_q)
      LOAD_A: begin
        if (s_vld) state_d = LOAD_B;
      end
      LOAD_B: begin
        if (s_vld) state_d = MAC;
      end
      MAC: begin
        if (feat_q == FEAT_LAST) begin
          feat_d  = '0;
          state_d = EXP;
        end else begin
          feat_d  = feat_q + FEAT_W'(1);
          state_d = LOAD_A;
        end
      end
      EXP: begin
        if (score_q == IDX_LAST) begin
          score_d = '0;
          state_d = SUM;
        end else begin
          score_d = score_q + IDX_W'(1);
          state_d = LOAD_A;
        end
      end
      SUM: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = NORM;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      NORM: begin
        // Without credit the FSM simply holds on the current slot.
        if (issue) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = LOAD_A;
      end
    endcase
  end

  // Moore control decode
  always_comb begin
    s_rdy    = 1'b0;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    ex_cap   = 1'b0;
    sum_en   = 1'b0;
    sum_clr  = 1'b0;
    m_vld    = 1'b0;
    row_done = 1'b0;
    case (state_q)
      LOAD_A, LOAD_B: s_rdy = 1'b1;
      MAC:            mac_en = 1'b1;
      EXP: begin
        ex_cap  = 1'b1;
        mac_clr = 1'b1;
      end
      SUM:            sum_en = 1'b1;
      NORM: begin
        m_vld = issue;
        if (issue && (idx_q == IDX_LAST)) begin
          row_done = 1'b1;
          sum_clr  = 1'b1;
        end
      end
      default: begin
        s_rdy = 1'b0;
      end
    endcase
  end

  // Operand staging. Each byte holds until its next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_a <= '0;
      mac_b <= '0;
    end else begin
      if ((state_q == LOAD_A) && s_vld) mac_a <= s_data;
      if ((state_q == LOAD_B) && s_vld) mac_b <= s_data;
    end
  end

  // Credit pool. A return that would exceed the pool is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= CRD_FULL;
      crd_err  <= 1'b0;
    end else begin
      if (issue && !crd_ret) begin
        credit_q <= credit_q - CRD_W'(1);
      end else if (!issue && crd_ret) begin
        if (credit_q == CRD_FULL) begin
          crd_err <= 1'b1;
        end else begin
          credit_q <= credit_q + CRD_W'(1);
        end
      end
    end
  end

`ifdef ATTN_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of NORM cycles blocked on credit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == NORM) && (credit_q == '0) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_attn_row_sequencer.sv
module tb_attn_row_sequencer;

  localparam int P_LA    = 0;
  localparam int P_LB    = 1;
  localparam int P_MAC   = 2;
  localparam int P_EXP   = 3;
  localparam int P_SUM   = 4;
  localparam int P_NORM  = 5;
  localparam int P_STALL = 6;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;

  // default-parameter instance
  logic [7:0]  s_data;
  logic        s_vld, s_rdy, mac_en, mac_clr, ex_cap, sum_en, sum_clr;
  logic [7:0]  mac_a, mac_b;
  logic [1:0]  ex_idx, idx;
  logic        m_vld, crd_ret, row_done, crd_err;
  logic [15:0] stall_cnt;

  // FEATURES=2, ROWLEN=8 instance
  logic [7:0]  s_data2;
  logic        s_vld2, s_rdy2, mac_en2, mac_clr2, ex_cap2, sum_en2, sum_clr2;
  logic [7:0]  mac_a2, mac_b2;
  logic [2:0]  ex_idx2, idx2;
  logic        m_vld2, crd_ret2, row_done2, crd_err2;
  logic [15:0] stall_cnt2;

  attn_row_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .ex_cap(ex_cap), .ex_idx(ex_idx), .sum_en(sum_en), .sum_clr(sum_clr),
    .idx(idx), .m_vld(m_vld), .crd_ret(crd_ret), .row_done(row_done),
    .crd_err(crd_err), .stall_cnt(stall_cnt)
  );

  attn_row_sequencer #(.FEATURES(2), .ROWLEN(8), .CREDITS(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .s_data(s_data2), .s_vld(s_vld2), .s_rdy(s_rdy2),
    .mac_a(mac_a2), .mac_b(mac_b2), .mac_en(mac_en2), .mac_clr(mac_clr2),
    .ex_cap(ex_cap2), .ex_idx(ex_idx2), .sum_en(sum_en2), .sum_clr(sum_clr2),
    .idx(idx2), .m_vld(m_vld2), .crd_ret(crd_ret2), .row_done(row_done2),
    .crd_err(crd_err2), .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  int          checks, failures, cyc, row_start, done_at;
  logic [7:0]  seed, exp_a, exp_b;
  int          exp_crd;
  logic        exp_err;
  logic [15:0] exp_stall;

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  // {s_rdy, mac_en, mac_clr, ex_cap, sum_en, sum_clr, m_vld, row_done}
  function automatic logic [7:0] exp_ctl(input int ph, input int ix, input int last);
    logic fin;
    fin = (ph == P_NORM) && (ix == last);
    return {(ph == P_LA) || (ph == P_LB), ph == P_MAC, ph == P_EXP, ph == P_EXP,
            ph == P_SUM, fin, ph == P_NORM, fin};
  endfunction

  task automatic check_reset(input string tag);
    chk(tag, "ctl", 32'({s_rdy, mac_en, mac_clr, ex_cap, sum_en, sum_clr, m_vld, row_done}), 32'h80);
    chk(tag, "ex_idx", 32'(ex_idx), 32'd0);
    chk(tag, "idx", 32'(idx), 32'd0);
    chk(tag, "mac_a", 32'(mac_a), 32'd0);
    chk(tag, "mac_b", 32'(mac_b), 32'd0);
    chk(tag, "crd_err", 32'(crd_err), 32'd0);
    chk(tag, "stall_cnt", 32'(stall_cnt), 32'd0);
  endtask

  // One cycle: check outputs of the expected phase, then drive inputs for its closing edge.
  task automatic tick(input int ph, input int ix, input logic vld, input logic ret, input string tag);
    logic [7:0] d;
    logic       iss;
    @(negedge clk);
    chk(tag, "ctl", 32'({s_rdy, mac_en, mac_clr, ex_cap, sum_en, sum_clr, m_vld, row_done}),
        32'(exp_ctl(ph, ix, 3)));
    if (ph == P_EXP) chk(tag, "ex_idx", 32'(ex_idx), 32'(ix));
    if (ph >= P_SUM) chk(tag, "idx", 32'(idx), 32'(ix));
    chk(tag, "mac_a", 32'(mac_a), 32'(exp_a));
    chk(tag, "mac_b", 32'(mac_b), 32'(exp_b));
    chk(tag, "crd_err", 32'(crd_err), 32'(exp_err));
`ifdef ATTN_SEQ_STALL_CNT_EN
    chk(tag, "stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`else
    chk(tag, "stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    if (row_done === 1'b1) done_at = cyc - row_start;
    d       = seed;
    seed    = seed + 8'd37;
    s_data  = d;
    s_vld   = vld;
    crd_ret = ret;
    if (vld && ph == P_LA) exp_a = d;
    if (vld && ph == P_LB) exp_b = d;
    iss = (ph == P_NORM);
    if (iss && !ret) exp_crd--;
    else if (!iss && ret) begin
      if (exp_crd == 4) exp_err = 1'b1;
      else exp_crd++;
    end
    if (ph == P_STALL && exp_stall != 16'hFFFF) exp_stall++;
    cyc++;
  endtask

  task automatic row_front(input int lb_wait, input int sum_n, input string tag);
    row_start = cyc;
    done_at   = -1;
    for (int s = 0; s < 4; s++) begin
      for (int f = 0; f < 4; f++) begin
        tick(P_LA, 0, 1'b1, 1'b0, tag);
        if (s == 0 && f == 0) begin
          for (int w = 0; w < lb_wait; w++) tick(P_LB, 0, 1'b0, 1'b0, tag);
        end
        tick(P_LB, 0, 1'b1, 1'b0, tag);
        tick(P_MAC, 0, 1'b1, 1'b0, tag);
      end
      tick(P_EXP, s, 1'b1, 1'b0, tag);
    end
    for (int i = 0; i < sum_n; i++) tick(P_SUM, i, 1'b1, 1'b0, tag);
  endtask

  task automatic norm_all(input logic ret, input string tag);
    for (int i = 0; i < 4; i++) tick(P_NORM, i, 1'b1, ret, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int ph2, ix2, p;
    checks = 0; failures = 0; cyc = 0; row_start = 0; done_at = -1;
    seed = 8'h40; exp_a = 8'h00; exp_b = 8'h00;
    exp_crd = 4; exp_err = 1'b0; exp_stall = 16'h0000;
    rst_n = 1'b0; rst2_n = 1'b0;
    s_vld = 1'b0; s_data = 8'h00; crd_ret = 1'b0;
    s_vld2 = 1'b0; s_data2 = 8'h00; crd_ret2 = 1'b0;

    repeat (3) @(negedge clk);
    check_reset("reset");
    chk("reset2", "s_rdy", 32'(s_rdy2), 32'd1);
    rst_n = 1'b1;

    // Full-rate rows with credits returned alongside each issue
    for (int k = 0; k < 4; k++) begin
      row_front(0, 4, "full_rate");
      norm_all(1'b1, "full_rate");
      chk("full_rate", "done_cycle", 32'(done_at), 32'd59);
    end

    // Five wait cycles in LOAD_B push row_done five cycles later
    row_front(5, 4, "lb_wait");
    norm_all(1'b1, "lb_wait");
    chk("lb_wait", "done_cycle", 32'(done_at), 32'd64);

    // Drain the pool, then stall the next row in NORM until credits trickle back
    row_front(0, 4, "no_ret");
    norm_all(1'b0, "no_ret");
    row_front(0, 4, "stall");
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < ((i == 0) ? 3 : 1); j++)
        tick(P_STALL, i, 1'b1, (j == ((i == 0) ? 2 : 0)), "stall");
      tick(P_NORM, i, 1'b1, 1'b0, "stall");
    end

    // Refill to full, then one extra return sets the sticky error
    for (int i = 0; i < 4; i++) tick(P_LA, 0, 1'b0, 1'b1, "refill");
    tick(P_LA, 0, 1'b0, 1'b1, "overflow");

    // Reset asserted during SUM idx=2 takes effect without a clock edge
    row_front(0, 3, "mid_rst");
    #2;
    rst_n = 1'b0; s_vld = 1'b0; crd_ret = 1'b0;
    #1;
    check_reset("async_rst");
    exp_a = 8'h00; exp_b = 8'h00; exp_crd = 4; exp_err = 1'b0; exp_stall = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    row_front(0, 4, "post_rst");
    norm_all(1'b1, "post_rst");
    chk("post_rst", "done_cycle", 32'(done_at), 32'd59);

    // FEATURES=2, ROWLEN=8: 7-cycle scores, 8-cycle SUM and NORM, 72-cycle row
    n_done = 0;
    rst2_n = 1'b1;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      if (c < 56) begin
        p = c % 7;
        if (p == 6) begin ph2 = P_EXP; ix2 = c / 7; end
        else begin ph2 = p % 3; ix2 = 0; end
      end else if (c < 64) begin
        ph2 = P_SUM; ix2 = c - 56;
      end else begin
        ph2 = P_NORM; ix2 = c - 64;
      end
      chk("rowlen8", "ctl", 32'({s_rdy2, mac_en2, mac_clr2, ex_cap2, sum_en2, sum_clr2, m_vld2, row_done2}),
          32'(exp_ctl(ph2, ix2, 7)));
      if (ph2 == P_EXP) chk("rowlen8", "ex_idx", 32'(ex_idx2), 32'(ix2));
      if (ph2 >= P_SUM) chk("rowlen8", "idx", 32'(idx2), 32'(ix2));
      if (row_done2 === 1'b1) begin
        n_done++;
        chk("rowlen8", "done_cycle", 32'(c), 32'd71);
      end
      s_vld2   = 1'b1;
      s_data2  = 8'(c);
      crd_ret2 = (ph2 == P_NORM);
    end
    @(negedge clk);
    chk("rowlen8", "done_count", 32'(n_done), 32'd1);
    chk("rowlen8", "next_s_rdy", 32'(s_rdy2), 32'd1);
    chk("rowlen8", "crd_err", 32'(crd_err2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
